// File: rtl/tick_debounce_pkg.sv
// tick_debounce_pkg: shared types and constants for the tick-sampled button debouncer.
//   deb_state_t       - per-channel debounce state
//   STABLE_TICKS_DEF  - default number of consecutive tick samples to accept a change
//   CNT_W             - width of the per-channel tick counter
package tick_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } deb_state_t;

    localparam int unsigned STABLE_TICKS_DEF = 4;
    localparam int unsigned CNT_W            = 4;

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel - 2-flop synchronizer, debounce FSM with tick counter,
// registered level and one-cycle press/release pulses.
//   clk_i      - system clock
//   rst_ni     - asynchronous active-low reset
//   tick_i     - single-cycle sample strobe (already reduced to its first high cycle)
//   raw_i      - asynchronous bouncing button pin, active-high
//   level_o    - debounced level
//   press_o    - one-cycle pulse on accepted press
//   release_o  - one-cycle pulse on accepted release
module debounce_chan
    import tick_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_TICKS);

    logic             sync1_q;
    logic             sync2_q;
    deb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Counter only ever climbs to STABLE_TICKS-1 before being cleared on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (tick_i) begin
                case (state_q)
                    RELEASED: begin
                        if (sync2_q) begin
                            state_q <= PRESS_PEND;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    PRESS_PEND: begin
                        if (!sync2_q) begin
                            state_q <= RELEASED;
                            cnt_q   <= '0;
                        end else if (cnt_inc == StableCnt) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    PRESSED: begin
                        if (!sync2_q) begin
                            state_q <= RELEASE_PEND;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    RELEASE_PEND: begin
                        if (sync2_q) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                        end else if (cnt_inc == StableCnt) begin
                            state_q   <= RELEASED;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/tick_debounce.sv
// tick_debounce: N_BTN independent tick-sampled button debouncers.
//   clk_in       - system clock, rising edge
//   rst_n        - asynchronous active-low reset
//   tick         - sample strobe from slow-clock divider
//   btn_raw      - asynchronous bouncing button pins
//   btn_level    - debounced levels
//   btn_press    - one-cycle pulses on accepted presses
//   btn_release  - one-cycle pulses on accepted releases
//   tick_err     - sticky: tick seen high on two or more consecutive cycles
module tick_debounce
    import tick_debounce_pkg::*;
#(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             tick_err
);

    logic tick_q;
    logic tick_err_q;
    logic tick_first;

    // A stuck-high strobe counts once; the extra high cycles only flag the error.
    assign tick_first = tick & ~tick_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_q     <= 1'b0;
            tick_err_q <= 1'b0;
        end else begin
            tick_q <= tick;
            if (tick && tick_q) begin
                tick_err_q <= 1'b1;
            end
        end
    end

    assign tick_err = tick_err_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk_i     (clk_in),
            .rst_ni    (rst_n),
            .tick_i    (tick_first),
            .raw_i     (btn_raw[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i])
        );
    end

endmodule

// File: tb/tb_tick_debounce.sv
// tb_tick_debounce: table-driven phases, hand-written corner sequences and random
// stimulus, all checked cycle-by-cycle against a behavioural model.
module tb_tick_debounce;

    localparam int NB = 5;
    localparam int ST = 3;

    logic          clk_in;
    logic          rst_n;
    logic          tick;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic          tick_err;

    tick_debounce #(
        .N_BTN        (NB),
        .STABLE_TICKS (ST)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .tick        (tick),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .tick_err    (tick_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: s is btn_raw delayed by two clock edges; a channel's level
    // flips once ST consecutive effective ticks have seen s differ from it.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_press;
    logic [NB-1:0] m_rel;
    logic          m_err;
    logic          m_prev_tick;
    int            m_run[NB];

    int press_cnt[NB];
    int rel_cnt[NB];
    bit all_same;

    typedef struct {
        logic [NB-1:0] raw;
        int            periods;
        logic [NB-1:0] exp_level;
        logic [NB-1:0] exp_press;
        logic [NB-1:0] exp_rel;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        m_level     = '0;
        m_press     = '0;
        m_rel       = '0;
        m_err       = 1'b0;
        m_prev_tick = 1'b0;
        for (int c = 0; c < NB; c++) m_run[c] = 0;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NB; c++) begin
            press_cnt[c] = 0;
            rel_cnt[c]   = 0;
        end
        all_same = 1'b0;
    endtask

    // Advance one clock: update the model from pre-edge inputs, then compare.
    task automatic step();
        logic [NB-1:0] s;
        bit teff;
        if (!rst_n) begin
            model_reset();
        end else begin
            s = hist.pop_front();
            hist.push_back(btn_raw);
            teff = tick && !m_prev_tick;
            if (tick && m_prev_tick) m_err = 1'b1;
            m_prev_tick = tick;
            m_press = '0;
            m_rel   = '0;
            if (teff) begin
                for (int c = 0; c < NB; c++) begin
                    if (s[c] != m_level[c]) begin
                        m_run[c]++;
                        if (m_run[c] == ST) begin
                            m_level[c] = ~m_level[c];
                            if (m_level[c]) m_press[c] = 1'b1;
                            else            m_rel[c]   = 1'b1;
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
        end
        @(posedge clk_in);
        #1;
        check("cycle", 32'({btn_level, btn_press, btn_release, tick_err}),
              32'({m_level, m_press, m_rel, m_err}));
        for (int c = 0; c < NB; c++) begin
            press_cnt[c] += int'(btn_press[c]);
            rel_cnt[c]   += int'(btn_release[c]);
        end
        if (btn_press == '1) all_same = 1'b1;
    endtask

    // One tick period of 10 cycles; the tick sits mid-period so s has settled.
    task automatic period(input logic [NB-1:0] raw);
        btn_raw = raw;
        repeat (5) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        vecs[0] = '{5'b00001, 3, 5'b00001, 5'b00001, 5'b00000};
        vecs[1] = '{5'b00011, 1, 5'b00001, 5'b00000, 5'b00000};
        vecs[2] = '{5'b00001, 1, 5'b00001, 5'b00000, 5'b00000};
        vecs[3] = '{5'b00011, 1, 5'b00001, 5'b00000, 5'b00000};
        vecs[4] = '{5'b00001, 1, 5'b00001, 5'b00000, 5'b00000};
        vecs[5] = '{5'b00101, 3, 5'b00101, 5'b00100, 5'b00000};
        vecs[6] = '{5'b00001, 3, 5'b00001, 5'b00000, 5'b00100};
        vecs[7] = '{5'b00000, 3, 5'b00000, 5'b00000, 5'b00001};
        vecs[8] = '{5'b11111, 3, 5'b11111, 5'b11111, 5'b00000};
        vecs[9] = '{5'b00000, 3, 5'b00000, 5'b00000, 5'b11111};

        rst_n   = 1'b0;
        tick    = 1'b0;
        btn_raw = '0;
        model_reset();
        clear_counts();
        repeat (3) step();
        check("reset_state", 32'({btn_level, btn_press, btn_release, tick_err}), 32'(0));
        rst_n = 1'b1;

        // Table-driven phases
        for (int v = 0; v < 10; v++) begin
            clear_counts();
            for (int p = 0; p < vecs[v].periods; p++) period(vecs[v].raw);
            check($sformatf("vec%0d_level", v), 32'(btn_level), 32'(vecs[v].exp_level));
            for (int c = 0; c < NB; c++) begin
                check($sformatf("vec%0d_press%0d", v, c), 32'(press_cnt[c]),
                      32'(vecs[v].exp_press[c]));
                check($sformatf("vec%0d_rel%0d", v, c), 32'(rel_cnt[c]),
                      32'(vecs[v].exp_rel[c]));
            end
            if (v == 8) check("all_press_same_cycle", 32'(all_same), 32'(1));
        end

        // Tick stuck high for 3 cycles: one advance, sticky error
        check("err_before_stuck", 32'(tick_err), 32'(0));
        clear_counts();
        btn_raw = 5'b00001;
        repeat (5) step();
        tick = 1'b1;
        repeat (3) step();
        tick = 1'b0;
        repeat (6) step();
        check("err_after_stuck", 32'(tick_err), 32'(1));
        period(5'b00001);
        check("stuck_no_early_press", 32'(press_cnt[0]), 32'(0));
        period(5'b00001);
        check("stuck_press_after_3", 32'(press_cnt[0]), 32'(1));
        check("stuck_level", 32'(btn_level[0]), 32'(1));
        check("err_sticky", 32'(tick_err), 32'(1));

        // Reset mid-PRESS_PEND: no pulse, re-qualify from scratch
        for (int p = 0; p < 3; p++) period(5'b00000);
        clear_counts();
        period(5'b00001);
        period(5'b00001);
        check("pre_reset_no_press", 32'(press_cnt[0]), 32'(0));
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({btn_level, btn_press, btn_release, tick_err}), 32'(0));
        repeat (3) step();
        check("reset_no_pulse", 32'(press_cnt[0] + rel_cnt[0]), 32'(0));
        rst_n = 1'b1;
        period(5'b00001);
        period(5'b00001);
        check("post_reset_no_press_2", 32'(press_cnt[0]), 32'(0));
        period(5'b00001);
        check("post_reset_press_3", 32'(press_cnt[0]), 32'(1));
        check("post_reset_level", 32'(btn_level[0]), 32'(1));

        // Random bouncing inputs and irregular ticks against the model
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 29) == 0) btn_raw[c] = ~btn_raw[c];
            end
            tick = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_debounce.md
TICK_DEBOUNCE -- requirements
Module: tick_debounce

Interface
REQ-001 The block SHALL have parameter N_BTN, default 5, meaning the number of independent button channels.
REQ-002 The block SHALL have parameter STABLE_TICKS, default 4, meaning the consecutive tick samples needed to accept a level change; legal range 2..15.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port tick, input, 1 bit: a one-cycle sample strobe from the slow-clock divider (one cycle high per period).
REQ-006 The block SHALL have port btn_raw, input, N_BTN bits: asynchronous, bouncing button pins, active-high.
REQ-007 The block SHALL have port btn_level, output, N_BTN bits: the debounced button level.
REQ-008 The block SHALL have port btn_press, output, N_BTN bits: a one-cycle pulse on each accepted press.
REQ-009 The block SHALL have port btn_release, output, N_BTN bits: a one-cycle pulse on each accepted release.
REQ-010 The block SHALL have port tick_err, output, 1 bit: sticky flag set when tick is high for 2 or more consecutive cycles.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer; the synchronized value s is the only value used by the state machine.
REQ-012 Each channel SHALL run a state machine with states RELEASED, PRESS_PEND, PRESSED and RELEASE_PEND, plus a tick counter cnt.
REQ-013 State and cnt SHALL change only in cycles where tick=1; in cycles where tick=0 they hold.
REQ-014 RELEASED: on a tick with s=1, the channel SHALL go to PRESS_PEND with cnt=1; on a tick with s=0 it stays in RELEASED.
REQ-015 PRESS_PEND: on a tick with s=1, cnt SHALL increment, and when the incremented value equals STABLE_TICKS the channel goes to PRESSED with cnt=0; on a tick with s=0 it returns to RELEASED with cnt=0.
REQ-016 PRESSED and RELEASE_PEND SHALL mirror REQ-014/REQ-015 with s inverted.
REQ-017 btn_level SHALL be 1 in PRESSED and RELEASE_PEND, and 0 otherwise; it is registered.
REQ-018 btn_press SHALL be high for exactly the one clock cycle after the tick that causes PRESS_PEND->PRESSED; btn_release SHALL behave the same for RELEASE_PEND->RELEASED.
REQ-019 btn_press and btn_release SHALL be low in every other cycle and SHALL never both be high on the same channel.
REQ-020 Channels SHALL be fully independent; simultaneous accepts on several channels SHALL pulse in the same cycle.
REQ-021 cnt width SHALL be 4 bits; cnt SHALL never exceed STABLE_TICKS-1 at rest, so wrap-around is impossible.
REQ-022 If tick is held high for k cycles, only the first cycle SHALL be treated as a tick, and tick_err SHALL set on the second consecutive high cycle and hold until reset.
REQ-023 Worst-case latency from a clean btn_raw edge to the pulse SHALL be 2 (synchronizer) + STABLE_TICKS tick periods + 1 cycle.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force every channel to RELEASED with cnt=0, btn_level=0, btn_press=0, btn_release=0, tick_err=0, and synchronizer flops=0.
REQ-025 Reset applied mid-PRESS_PEND or while PRESSED SHALL produce no press or release pulse; after release, a button still held SHALL be re-qualified from RELEASED.
REQ-026 Reset release SHALL be synchronized externally; the block SHALL not rely on it being glitch-free beyond the asynchronous assert.

Structure
REQ-027 The shared package SHALL hold the deb_state_t enum (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND) and the default STABLE_TICKS constant.
REQ-028 A single sub-module, debounce_chan (synchronizer, FSM, counter, pulse regs), SHALL be instantiated N_BTN times; the top level SHALL hold the tick first-cycle detection and tick_err.

Verification
REQ-029 Test parameters are STABLE_TICKS=3 with tick every 10 cycles. Scenario: btn_raw[0] held at 1 -> btn_press[0] is a single 1-cycle pulse after the 3rd qualifying tick, and btn_level[0]=1 from that cycle.
REQ-030 Scenario: btn_raw[1] toggles 1,0,1 across ticks 1-3 -> no btn_press[1]; the channel returns to RELEASED.
REQ-031 Scenario: channel 2 PRESSED, then btn_raw[2]=0 for 3 ticks -> a single btn_release[2] pulse and btn_level[2]=0.
REQ-032 Scenario: all 5 buttons asserted in the same cycle -> all 5 btn_press bits pulse in the same cycle.
REQ-033 Scenario: tick held high for 3 cycles -> the FSM advances once and tick_err=1 stays set until rst_n=0.
REQ-034 Scenario: rst_n=0 asserted after 2 qualifying ticks with the button held -> outputs are 0 immediately, with no pulse; after rst_n=1, the press pulse arrives 3 ticks later.
